// File: rtl/led_blink_multi.sv
// -----------------------------------------------------------------------------
// led_blink_multi
//
// Multi-channel LED blink controller. A shared prescaler divides in_clk down to
// a one-cycle timebase strobe at TICK_HZ. Every channel owns a half-period
// counter that counts those strobes and fires a "half-period event" each time
// it wraps. Each channel turns those events into an LED drive according to its
// own mode:
//   00 off    - LED unlit
//   01 on     - LED lit
//   10 blink  - LED toggles on every event (50% duty, starts unlit)
//   11 burst  - BURST_N on-pulses, then a pause of 2*BURST_N events unlit
//
// Optional feature (macro LED_BLINK_DIM_EN):
//   Adds an 8-bit `dim` input and a free-running 8-bit PWM counter. Every lit
//   output is gated with (pwm_cnt < dim), so dim=0 is always dark and dim=255
//   gives 255/256 duty. Without the macro there is no `dim` port and the LED
//   drive is the lit value directly.
//
// Parameters:
//   OSC_CLOCK  in_clk frequency in Hz
//   TICK_HZ    timebase rate in Hz; DIV = OSC_CLOCK/TICK_HZ must be >= 2
//   CHANNELS   number of LED outputs (1..32)
//   PERIOD_W   width of each per-channel half-period field (ticks)
//   BURST_N    on-pulses per burst (>= 1)
//
// Ports:
//   in_clk       system clock
//   reset_n      asynchronous active-low reset
//   mode         per-channel mode, ch k = mode[2k+1:2k]
//   half_period  per-channel half-period in ticks, ch k = [PERIOD_W*(k+1)-1:PERIOD_W*k]
//                (0 is treated as 1)
//   sync         synchronous phase restart: clears prescaler, tick, PWM and
//                every channel's counters/phase/burst state
//   dim          (LED_BLINK_DIM_EN only) 8-bit brightness
//   flash        registered LED drive, 1 = lit
//   tick         registered timebase strobe, high 1 cycle every DIV cycles
//
// Control inputs (mode, half_period, dim) are static register-block levels;
// there is no valid/ready handshake anywhere in this block. sync is a plain
// level sampled on every rising edge of in_clk.
// -----------------------------------------------------------------------------
module led_blink_multi #(
    parameter int OSC_CLOCK = 27000000,
    parameter int TICK_HZ   = 1000,
    parameter int CHANNELS  = 4,
    parameter int PERIOD_W  = 16,
    parameter int BURST_N   = 3
) (
    input  logic                         in_clk,
    input  logic                         reset_n,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PERIOD_W*CHANNELS-1:0] half_period,
    input  logic                         sync,
`ifdef LED_BLINK_DIM_EN
    input  logic [7:0]                   dim,
`endif
    output logic [CHANNELS-1:0]          flash,
    output logic                         tick
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int DIV   = OSC_CLOCK / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);                 // DIV >= 2 so PRE_W >= 1
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    // bcnt counts 1->0 transitions while running (up to BURST_N-1) and events
    // while pausing (up to 2*BURST_N-1); size it for the larger of the two.
    localparam int BC_W = $clog2(2 * BURST_N + 1);
    localparam logic [BC_W-1:0] RUN_LAST   = BC_W'(BURST_N - 1);
    localparam logic [BC_W-1:0] PAUSE_LAST = BC_W'(2 * BURST_N - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // Burst sub-FSM states; the state register doubles as the "pausing" flag.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_PAUSE = 1'b1;

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    // tick_now is the combinational "this edge is a timebase edge" strobe. The
    // channels advance on the same edge that raises the registered tick, so
    // every LED change lines up with the tick output.
    logic [PRE_W-1:0] pre_cnt;
    logic             tick_now;

    assign tick_now = (pre_cnt == PRE_LAST);

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (sync) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= tick_now;
            pre_cnt <= tick_now ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Optional PWM dimming
    // -------------------------------------------------------------------------
    logic pwm_on;

`ifdef LED_BLINK_DIM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else if (sync) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign pwm_on = (pwm_cnt < dim);
`else
    assign pwm_on = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Per-channel engines
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [1:0]          m_in;
        logic [PERIOD_W-1:0] hp_in;
        logic [PERIOD_W-1:0] hp_last;   // max(half_period,1) - 1

        logic [1:0]          m_q;
        logic [PERIOD_W-1:0] cnt;
        logic                phase;
        logic [BC_W-1:0]     bcnt;
        logic [0:0]          state;
        logic                flash_q;

        logic [PERIOD_W-1:0] cnt_d;
        logic                phase_d;
        logic [BC_W-1:0]     bcnt_d;
        logic [0:0]          state_d;
        logic                evt;
        logic                lit_d;

        assign m_in    = mode[2*k +: 2];
        assign hp_in   = half_period[PERIOD_W*k +: PERIOD_W];
        assign hp_last = (hp_in == '0) ? '0 : hp_in - PERIOD_W'(1);

        always_comb begin
            cnt_d   = cnt;
            phase_d = phase;
            bcnt_d  = bcnt;
            state_d = state;
            evt     = 1'b0;
            lit_d   = 1'b0;

            // Restart (sync or mode change) wins over a coincident tick.
            if (sync || (m_in != m_q)) begin
                cnt_d   = '0;
                phase_d = 1'b0;
                bcnt_d  = '0;
                state_d = ST_RUN;
            end else if (tick_now) begin
                // ">=" rather than "==" so that shrinking half_period below the
                // current count still wraps on the very next tick.
                if (cnt >= hp_last) begin
                    cnt_d = '0;
                    evt   = 1'b1;
                end else begin
                    cnt_d = cnt + PERIOD_W'(1);
                end
            end

            if (evt) begin
                case (m_q)
                    MODE_BLINK: begin
                        phase_d = ~phase;
                    end
                    MODE_BURST: begin
                        if (state == ST_RUN) begin
                            if (phase) begin
                                // Falling edge of an on-pulse ends one pulse.
                                phase_d = 1'b0;
                                if (bcnt == RUN_LAST) begin
                                    bcnt_d  = '0;
                                    state_d = ST_PAUSE;
                                end else begin
                                    bcnt_d = bcnt + BC_W'(1);
                                end
                            end else begin
                                phase_d = 1'b1;
                            end
                        end else begin
                            // Pausing: bcnt counts events until the gap ends.
                            phase_d = 1'b0;
                            if (bcnt == PAUSE_LAST) begin
                                bcnt_d  = '0;
                                state_d = ST_RUN;
                            end else begin
                                bcnt_d = bcnt + BC_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // Drive from next-state values so a mode write is visible one cycle
            // after the input changes and an event is visible with its tick.
            case (m_in)
                MODE_OFF:   lit_d = 1'b0;
                MODE_ON:    lit_d = 1'b1;
                MODE_BLINK: lit_d = phase_d;
                MODE_BURST: lit_d = phase_d & (state_d == ST_RUN);
                default:    lit_d = 1'b0;
            endcase
        end

        always_ff @(posedge in_clk or negedge reset_n) begin
            if (!reset_n) begin
                m_q     <= MODE_OFF;
                cnt     <= '0;
                phase   <= 1'b0;
                bcnt    <= '0;
                state   <= ST_RUN;
                flash_q <= 1'b0;
            end else begin
                m_q     <= m_in;
                cnt     <= cnt_d;
                phase   <= phase_d;
                bcnt    <= bcnt_d;
                state   <= state_d;
                flash_q <= lit_d & pwm_on;
            end
        end

        assign flash[k] = flash_q;
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// -----------------------------------------------------------------------------
// tb_led_blink_multi
//
// Directed bench for led_blink_multi with OSC_CLOCK=1000, TICK_HZ=100 (DIV=10),
// CHANNELS=4, PERIOD_W=16, BURST_N=2. Edge numbering: edge 0 is the reset
// release point, edge e is the e-th rising edge after it, and outputs are
// sampled 1 time unit after edge e. Inputs written at that point are first
// seen by the DUT on edge e+1.
// -----------------------------------------------------------------------------
module tb_led_blink_multi;

    localparam int CH = 4;
    localparam int PW = 16;

    logic              in_clk;
    logic              reset_n;
    logic [2*CH-1:0]   mode;
    logic [PW*CH-1:0]  half_period;
    logic              sync;
    logic [CH-1:0]     flash;
    logic              tick;
`ifdef LED_BLINK_DIM_EN
    logic [7:0]        dim;
`endif

    int vectors = 0;
    int errors  = 0;
    int edge_n  = 0;

    led_blink_multi #(
        .OSC_CLOCK (1000),
        .TICK_HZ   (100),
        .CHANNELS  (CH),
        .PERIOD_W  (PW),
        .BURST_N   (2)
    ) dut (
        .in_clk      (in_clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .half_period (half_period),
        .sync        (sync),
`ifdef LED_BLINK_DIM_EN
        .dim         (dim),
`endif
        .flash       (flash),
        .tick        (tick)
    );

    // ---------------- clock ----------------
    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic adv_to(input int e);
        while (edge_n < e) begin
            @(posedge in_clk);
            edge_n++;
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge in_clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_flash", 32'(flash), 32'h0);
        chk("async_reset_tick", 32'(tick), 32'h0);
        repeat (2) @(negedge in_clk);
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] burst_pat;
        int         t;
        int         ones;
        logic       exp_f0;
        logic       exp_f1;
        logic       exp_f2;
        logic       exp_t;

        reset_n     = 1'b0;
        sync        = 1'b0;
        mode        = '0;
        half_period = {16'd1, 16'd1, 16'd1, 16'd1};
`ifdef LED_BLINK_DIM_EN
        dim         = 8'd255;
`endif

        // ---- 1: all channels off, tick cadence ----
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            adv_to(e);
            chk("off_flash", 32'(flash), 32'h0);
            chk("tick_cadence", 32'(tick), ((e % 10) == 0) ? 32'h1 : 32'h0);
        end

        // ---- 2: ch0 blink hp=3, ch1 burst hp=1, ch2 switched on at edge 40 ----
        mode        = {2'b00, 2'b00, 2'b11, 2'b10};
        half_period = {16'd1, 16'd1, 16'd1, 16'd3};
        do_reset();
        // Burst with BURST_N=2: per tick 1,0,1,0 then 4 dark ticks.
        burst_pat = 8'b0000_0101;
        for (int e = 1; e <= 100; e++) begin
            adv_to(e);
            exp_f0 = ((e / 30) % 2) == 1;
            t      = e / 10;
            exp_f1 = (t == 0) ? 1'b0 : burst_pat[(t - 1) % 8];
            exp_f2 = (e >= 41);
            chk("blink_hp3_ch0", 32'(flash[0]), 32'(exp_f0));
            chk("burst_ch1", 32'(flash[1]), 32'(exp_f1));
            chk("on_ch2", 32'(flash[2]), 32'(exp_f2));
            chk("idle_ch3", 32'(flash[3]), 32'h0);
            if (e == 40) mode[5:4] = 2'b01;
        end

        // ---- 3: sync mid-phase at edge 37, ch0 blink hp=5 ----
        mode        = {2'b00, 2'b00, 2'b00, 2'b10};
        half_period = {16'd1, 16'd1, 16'd1, 16'd5};
        do_reset();
        adv_to(36);
        chk("pre_sync_flash", 32'(flash), 32'h0);
        sync = 1'b1;
        adv_to(37);
        sync = 1'b0;
        chk("sync_tick_clear", 32'(tick), 32'h0);
        for (int e = 38; e <= 100; e++) begin
            adv_to(e);
            exp_t  = (e >= 47) && (((e - 47) % 10) == 0);
            exp_f0 = (e >= 87);
            chk("sync_tick", 32'(tick), 32'(exp_t));
            chk("sync_blink_ch0", 32'(flash[0]), 32'(exp_f0));
        end

        // ---- 4: ch3 blink hp=0 (treated as 1), then hp 100 -> 2 at cnt=50 ----
        mode        = {2'b10, 2'b00, 2'b00, 2'b00};
        half_period = {16'd0, 16'd1, 16'd1, 16'd1};
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            adv_to(e);
            chk("hp0_toggle_ch3", 32'(flash[3]), 32'((e / 10) % 2));
        end
        half_period[63:48] = 16'd100;
        for (int e = 61; e <= 560; e += 50) begin
            adv_to(e);
            chk("hp100_hold_ch3", 32'(flash[3]), 32'h0);
        end
        adv_to(569);
        chk("hp100_before_ch3", 32'(flash[3]), 32'h0);
        adv_to(560);
        half_period[63:48] = 16'd2;
        adv_to(569);
        chk("hp_shrink_wait_ch3", 32'(flash[3]), 32'h0);
        adv_to(570);
        chk("hp_shrink_toggle_ch3", 32'(flash[3]), 32'h1);
        adv_to(589);
        chk("hp2_hold_ch3", 32'(flash[3]), 32'h1);
        adv_to(590);
        chk("hp2_toggle_ch3", 32'(flash[3]), 32'h0);

        // ---- 5: mode change coincident with a tick restarts the channel ----
        mode        = {2'b00, 2'b00, 2'b00, 2'b10};
        half_period = {16'd1, 16'd1, 16'd1, 16'd1};
        do_reset();
        adv_to(10);
        chk("blink_hp1_first", 32'(flash[0]), 32'h1);
        adv_to(19);
        mode[1:0] = 2'b11;
        adv_to(20);
        chk("mode_change_prio", 32'(flash[0]), 32'h0);
        adv_to(30);
        chk("burst_after_change", 32'(flash[0]), 32'h1);

`ifdef LED_BLINK_DIM_EN
        // ---- 6: PWM dimming on an always-on channel ----
        mode        = {2'b00, 2'b01, 2'b00, 2'b00};
        dim         = 8'd64;
        do_reset();
        ones = 0;
        for (int e = 1; e <= 256; e++) begin
            adv_to(e);
            ones += int'(flash[2]);
        end
        chk("dim64_duty", 32'(ones), 32'd64);
        dim  = 8'd0;
        adv_to(257);
        ones = 0;
        for (int e = 258; e <= 513; e++) begin
            adv_to(e);
            ones += int'(flash[2]);
        end
        chk("dim0_dark", 32'(ones), 32'd0);
`else
        ones = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
